// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and the
// instruction memory (slave). One request per ImemReq strobe, at most
// one ImemValid response per request, never in the same cycle.
interface fetch_stage_if;
   logic        ImemReq;
   logic [63:0] ImemAddr;
   logic [31:0] ImemRdata;
   logic        ImemValid;

   modport master (
      output ImemReq,
      output ImemAddr,
      input  ImemRdata,
      input  ImemValid
   );

   modport slave (
      input  ImemReq,
      input  ImemAddr,
      output ImemRdata,
      output ImemValid
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage plus IF/ID pipeline register.
// Owns the PC, keeps exactly one request in flight to a variable-latency
// instruction memory, and hands InstrD/PCD/PCPlus4D to decode. Stall holds
// the pipeline, flush inserts a bubble, and a taken branch/jump redirects
// the PC while any in-flight response is drained and thrown away.
module fetch_stage #(
   parameter logic [63:0] RESET_PC  = 64'h0000_0000_0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 StallF_i,
   input  logic                 FlushD_i,
   input  logic                 PCSrcE_i,
   input  logic [63:0]          PCTargetE_i,
   fetch_stage_if.master        imem,
   output logic [31:0]          InstrD_o,
   output logic [63:0]          PCD_o,
   output logic [63:0]          PCPlus4D_o,
   output logic                 ValidD_o
);

   // ISSUE : send a request for PCF this cycle
   // WAIT  : request in flight; a response may chain the next request
   // HOLD  : response arrived during a stall, parked in HoldBuf
   // DRAIN : redirected with a request in flight; swallow its response
   typedef enum logic [1:0] {
      S_ISSUE = 2'd0,
      S_WAIT  = 2'd1,
      S_HOLD  = 2'd2,
      S_DRAIN = 2'd3
   } state_e;

   // Sequential PC increment; wraps modulo 2^64 by construction.
   function automatic logic [63:0] pc_inc(input logic [63:0] pc);
      pc_inc = pc + 64'd4;
   endfunction

   state_e      state_q, state_d;
   logic [63:0] pcf_q, pcf_d;
   logic [31:0] hold_q, hold_d;

   logic [31:0] instr_d_q, instr_d_d;
   logic [63:0] pcd_q, pcd_d;
   logic [63:0] pcplus4d_q, pcplus4d_d;
   logic        valid_d_q, valid_d_d;

   logic [63:0] pcf_plus4_s;
   logic [63:0] target_s;
   logic        req_s;
   logic [63:0] addr_s;
   logic        deliver_s;
   logic [31:0] deliver_instr_s;

   assign pcf_plus4_s = pc_inc(pcf_q);
   // Instructions are word aligned; low two target bits are ignored.
   assign target_s    = PCTargetE_i & ~64'd3;

   // Fetch FSM: next state, next PC, hold buffer and memory request.
   always_comb begin
      state_d         = state_q;
      pcf_d           = pcf_q;
      hold_d          = hold_q;
      req_s           = 1'b0;
      addr_s          = pcf_q;
      deliver_s       = 1'b0;
      deliver_instr_s = NOP_INSTR;
      case (state_q)
         S_ISSUE: begin
            // The request goes out even on a redirect; DRAIN absorbs it.
            req_s = 1'b1;
            if (PCSrcE_i) begin
               pcf_d   = target_s;
               state_d = S_DRAIN;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (!imem.ImemValid) begin
               if (PCSrcE_i) begin
                  pcf_d   = target_s;
                  state_d = S_DRAIN;
               end else begin
                  state_d = S_WAIT;
               end
            end else if (PCSrcE_i) begin
               // Response is consumed and dropped; nothing left in flight.
               pcf_d   = target_s;
               state_d = S_ISSUE;
            end else if (StallF_i) begin
               hold_d  = imem.ImemRdata;
               state_d = S_HOLD;
            end else begin
               // Deliver and chain the next request in the same cycle.
               deliver_s       = 1'b1;
               deliver_instr_s = imem.ImemRdata;
               pcf_d           = pcf_plus4_s;
               req_s           = 1'b1;
               addr_s          = pcf_plus4_s;
               state_d         = S_WAIT;
            end
         end
         S_HOLD: begin
            if (PCSrcE_i) begin
               // Parked word belongs to the wrong path; abandon it.
               pcf_d   = target_s;
               state_d = S_ISSUE;
            end else if (!StallF_i) begin
               deliver_s       = 1'b1;
               deliver_instr_s = hold_q;
               pcf_d           = pcf_plus4_s;
               state_d         = S_ISSUE;
            end else begin
               state_d = S_HOLD;
            end
         end
         S_DRAIN: begin
            if (PCSrcE_i) begin
               pcf_d = target_s;
            end else begin
               pcf_d = pcf_q;
            end
            // Leave as soon as the stale response is swallowed so the
            // bus can never be left without a request in flight.
            if (imem.ImemValid) begin
               state_d = S_ISSUE;
            end else begin
               state_d = S_DRAIN;
            end
         end
         default: begin
            state_d = S_ISSUE;
         end
      endcase
   end

   // IF/ID next value: flush beats delivery, delivery beats stall.
   always_comb begin
      instr_d_d  = instr_d_q;
      pcd_d      = pcd_q;
      pcplus4d_d = pcplus4d_q;
      valid_d_d  = valid_d_q;
      if (FlushD_i) begin
         instr_d_d = NOP_INSTR;
         valid_d_d = 1'b0;
      end else if (deliver_s) begin
         instr_d_d  = deliver_instr_s;
         pcd_d      = pcf_q;
         pcplus4d_d = pcf_plus4_s;
         valid_d_d  = 1'b1;
      end else if (StallF_i) begin
         instr_d_d = instr_d_q;
         valid_d_d = valid_d_q;
      end else begin
         // Nothing arrived: bubble, but keep the last PC for debug/trace.
         instr_d_d = NOP_INSTR;
         valid_d_d = 1'b0;
      end
   end

   // State, PC, hold buffer and IF/ID registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_ISSUE;
         pcf_q      <= RESET_PC;
         hold_q     <= 32'h0000_0000;
         instr_d_q  <= NOP_INSTR;
         pcd_q      <= 64'h0000_0000_0000_0000;
         pcplus4d_q <= 64'h0000_0000_0000_0000;
         valid_d_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         pcf_q      <= pcf_d;
         hold_q     <= hold_d;
         instr_d_q  <= instr_d_d;
         pcd_q      <= pcd_d;
         pcplus4d_q <= pcplus4d_d;
         valid_d_q  <= valid_d_d;
      end
   end

   // The request must be combinational so a response can chain the next
   // fetch in the same cycle; it is masked while reset is held.
   assign imem.ImemReq  = req_s & ~rst;
   assign imem.ImemAddr = addr_s;

   assign InstrD_o   = instr_d_q;
   assign PCD_o      = pcd_q;
   assign PCPlus4D_o = pcplus4d_q;
   assign ValidD_o   = valid_d_q;

endmodule
